// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: default widths plus the
// launcher and transmitter state encodings, kept together so the feeder and
// the transmitter agree on them.
package uart_tx_fifo_pkg;

  localparam int DBIT_DEFAULT      = 8;
  localparam int ADDR_BITS_DEFAULT = 4;

  // Launcher FSM that drains the FIFO into the transmitter.
  typedef enum logic [1:0] {
    L_IDLE      = 2'd0,
    L_LAUNCH    = 2'd1,
    L_WAIT_DONE = 2'd2
  } launch_state_e;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Register-file storage for the transmit FIFO: one synchronous write port and
// one combinational read port.
module uart_fifo_ram
  import uart_tx_fifo_pkg::*;
#(
  parameter int DBIT      = DBIT_DEFAULT,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic                 i_clock,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [DBIT-1:0]      i_wr_data,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [DBIT-1:0]      o_rd_data
);

  logic [DBIT-1:0] mem [2**ADDR_BITS];

  // Store the incoming byte at the write address.
  // NOTE: the array has no reset; the pointers and count alone decide which
  // entries are valid, so clearing it would only cost reset fan-out.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side FIFO and launcher: buffers bytes from bursty producers and
// hands them to the UART transmitter one at a time, one start pulse per byte,
// waiting for the transmitter's done tick before launching the next.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DBIT      = DBIT_DEFAULT,
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_wr,
  input  logic [DBIT-1:0]    i_wr_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [ADDR_BITS:0] o_count,
  output logic               o_overflow,
  output logic               o_tx_start,
  output logic [DBIT-1:0]    o_tx_data,
  input  logic               i_tx_done_tick
);

  localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

  launch_state_e        state_q, state_d;
  logic [ADDR_BITS-1:0] wptr_q, wptr_d;
  logic [ADDR_BITS-1:0] rptr_q, rptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 tx_start_q, tx_start_d;
  logic [DBIT-1:0]      tx_data_q, tx_data_d;
  logic [DBIT-1:0]      rd_data;
  logic                 wr_en;
  logic                 pop;

  uart_fifo_ram #(
    .DBIT      (DBIT),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .i_clock   (i_clock),
    .i_wr_en   (wr_en),
    .i_wr_addr (wptr_q),
    .i_wr_data (i_wr_data),
    .i_rd_addr (rptr_q),
    .o_rd_data (rd_data)
  );

  // Status decodes; a write while full is dropped even if a pop frees a slot
  // in the same cycle, which keeps the overflow pulse a pure function of now.
  assign o_full     = (count_q == DEPTH);
  assign o_empty    = (count_q == '0);
  assign o_overflow = i_wr & o_full;
  assign wr_en      = i_wr & ~o_full;
  assign pop        = (state_q == L_IDLE) & ~o_empty;

  assign o_count    = count_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;

  // Next-state logic for pointers, occupancy, launcher FSM and its outputs.
  // NOTE: every target gets its hold value first so no path leaves it
  // unassigned, which is what keeps this block from inferring latches.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;

    if (wr_en) wptr_d = wptr_q + 1'b1;

    if (pop) begin
      rptr_d    = rptr_q + 1'b1;
      tx_data_d = rd_data;
    end

    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    unique case (state_q)
      L_IDLE:      if (pop) state_d = L_LAUNCH;
      L_LAUNCH:    state_d = L_WAIT_DONE;
      L_WAIT_DONE: if (i_tx_done_tick) state_d = L_IDLE;
      default:     state_d = L_IDLE;
    endcase

    // The start pulse is high exactly while the FSM sits in LAUNCH.
    tx_start_d = (state_d == L_LAUNCH);
  end

  // State register with asynchronous active-low clear.
  // NOTE: non-blocking assignments so every register samples the pre-edge
  // values, independent of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= L_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. A queue of accepted-but-not-popped
// bytes is the reference: each launch must carry the oldest byte, occupancy
// must equal the queue size, and writes while the queue holds 16 are dropped.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       i_clock        = 1'b0;
  logic       i_reset        = 1'b1;
  logic       i_wr           = 1'b0;
  logic [7:0] i_wr_data      = 8'h00;
  logic       i_tx_done_tick = 1'b0;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_count;
  logic       o_overflow;
  logic       o_tx_start;
  logic [7:0] o_tx_data;

  uart_tx_fifo #(.DBIT(8), .ADDR_BITS(4)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_wr           (i_wr),
    .i_wr_data      (i_wr_data),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .i_tx_done_tick (i_tx_done_tick)
  );

  always #5 i_clock = ~i_clock;

  int         tests    = 0;
  int         fails    = 0;
  logic [7:0] exp_q[$];
  bit         busy      = 1'b0;
  bit         auto_done = 1'b0;
  int         done_timer = 0;
  int         launches  = 0;
  logic [7:0] last_data = 8'h00;

  logic       s_start, s_full, s_empty, s_overflow;
  logic [4:0] s_count;
  logic [7:0] s_data;

  // Sample outputs mid-cycle and compare them with the queue model.
  task automatic monitor();
    logic [7:0] exp_b;
    bit         exp_ovf;
    s_start = o_tx_start; s_full = o_full; s_empty = o_empty;
    s_overflow = o_overflow; s_count = o_count; s_data = o_tx_data;
    if (!i_reset) return;
    if (o_tx_start) begin
      tests++;
      if (busy) begin
        fails++;
        $display("FAIL launch_while_busy: o_tx_start=1 with a byte outstanding, expected 0");
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_launch: o_tx_start=1 data=%02h, expected no launch", o_tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (o_tx_data !== exp_b) begin
          fails++;
          $display("FAIL tx_data_order: got %02h, expected %02h", o_tx_data, exp_b);
        end
      end
      busy = 1'b1;
      launches++;
      done_timer = $urandom_range(0, 5);
    end else begin
      tests++;
      if (o_tx_data !== last_data) begin
        fails++;
        $display("FAIL tx_data_hold: changed to %02h without launch, expected %02h", o_tx_data, last_data);
      end
      if (auto_done && busy) begin
        if (done_timer == 0) i_tx_done_tick = 1'b1;
        else done_timer--;
      end
    end
    last_data = o_tx_data;
    tests++;
    if (o_count !== 5'(exp_q.size())) begin
      fails++;
      $display("FAIL count: got %0d, expected %0d", o_count, exp_q.size());
    end
    tests++;
    if (o_empty !== (exp_q.size() == 0) || o_full !== (exp_q.size() == DEPTH)) begin
      fails++;
      $display("FAIL flags: empty=%b full=%b, expected empty=%b full=%b",
               o_empty, o_full, exp_q.size() == 0, exp_q.size() == DEPTH);
    end
    exp_ovf = i_wr && (exp_q.size() == DEPTH);
    tests++;
    if (o_overflow !== exp_ovf) begin
      fails++;
      $display("FAIL overflow: got %b, expected %b", o_overflow, exp_ovf);
    end
    if (i_wr && !exp_ovf) exp_q.push_back(i_wr_data);
  endtask

  // One clock: check mid-cycle, then return just after the next rising edge.
  task automatic step();
    @(negedge i_clock);
    monitor();
    @(posedge i_clock);
    if (i_tx_done_tick) busy = 1'b0;
    #1;
    if (auto_done) i_tx_done_tick = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    i_wr = 1'b1; i_wr_data = d;
    step();
    i_wr = 1'b0;
  endtask

  task automatic pulse_done();
    i_tx_done_tick = 1'b1;
    step();
    i_tx_done_tick = 1'b0;
  endtask

  // Manually acknowledge every launch until the model is drained.
  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      if (busy) pulse_done();
      else step();
      n++;
    end
    tests++;
    if (n >= budget) begin
      fails++;
      $display("FAIL drain_timeout: %0d bytes still queued, expected 0", exp_q.size());
    end
    step();
  endtask

  task automatic test_reset();
    #1 i_reset = 1'b0;
    #1;
    tests++;
    if (o_empty !== 1'b1 || o_full !== 1'b0 || o_count !== 5'd0 || o_overflow !== 1'b0 ||
        o_tx_start !== 1'b0 || o_tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_values: empty=%b full=%b count=%0d ovf=%b start=%b data=%02h, expected 1 0 0 0 0 00",
               o_empty, o_full, o_count, o_overflow, o_tx_start, o_tx_data);
    end
    @(posedge i_clock); #1;
    i_reset = 1'b1;
    repeat (6) step();
    tests++;
    if (launches !== 0) begin
      fails++;
      $display("FAIL idle_after_reset: %0d launches, expected 0", launches);
    end
  endtask

  task automatic test_single();
    int l0 = launches;
    write_byte(8'hA5);
    step();
    tests++;
    if (s_start !== 1'b0 || s_empty !== 1'b0) begin
      fails++;
      $display("FAIL single_after_write: start=%b empty=%b, expected 0 0", s_start, s_empty);
    end
    step();
    tests++;
    if (s_start !== 1'b1 || s_data !== 8'hA5) begin
      fails++;
      $display("FAIL single_launch: start=%b data=%02h, expected 1 a5", s_start, s_data);
    end
    repeat (6) step();
    tests++;
    if (launches - l0 !== 1) begin
      fails++;
      $display("FAIL single_one_pulse: %0d launches, expected 1", launches - l0);
    end
    pulse_done();
    repeat (3) step();
  endtask

  task automatic test_burst_overflow();
    int l0 = launches;
    write_byte(8'h00);
    for (int i = 1; i <= 16; i++) write_byte(8'(i));
    step();
    tests++;
    if (s_full !== 1'b1 || s_count !== 5'd16) begin
      fails++;
      $display("FAIL burst_full: full=%b count=%0d, expected 1 16", s_full, s_count);
    end
    i_wr = 1'b1; i_wr_data = 8'hFF;
    step();
    i_wr = 1'b0;
    tests++;
    if (s_overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_pulse: got %b, expected 1", s_overflow);
    end
    step();
    tests++;
    if (s_overflow !== 1'b0 || s_count !== 5'd16) begin
      fails++;
      $display("FAIL overflow_after: ovf=%b count=%0d, expected 0 16", s_overflow, s_count);
    end
    drain(400);
    tests++;
    if (launches - l0 !== 17 || s_empty !== 1'b1) begin
      fails++;
      $display("FAIL burst_drain: launches=%0d empty=%b, expected 17 1", launches - l0, s_empty);
    end
  endtask

  task automatic test_simultaneous();
    int l0 = launches;
    write_byte(8'h30);
    step(); step();
    write_byte(8'h31); write_byte(8'h32); write_byte(8'h33);
    pulse_done();
    i_wr = 1'b1; i_wr_data = 8'h34;
    step();
    i_wr = 1'b0;
    step();
    tests++;
    if (s_start !== 1'b1 || s_count !== 5'd3 || s_data !== 8'h31) begin
      fails++;
      $display("FAIL simul_wr_pop: start=%b count=%0d data=%02h, expected 1 3 31", s_start, s_count, s_data);
    end
    drain(200);
    tests++;
    if (launches - l0 !== 5) begin
      fails++;
      $display("FAIL simul_total: %0d launches, expected 5", launches - l0);
    end
  endtask

  task automatic test_reset_mid();
    int l0;
    for (int i = 0; i < 5; i++) write_byte(8'($urandom));
    step(); step();
    i_reset = 1'b0;
    #1;
    tests++;
    if (o_count !== 5'd0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_tx_start !== 1'b0 || o_tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid: count=%0d empty=%b full=%b start=%b data=%02h, expected 0 1 0 0 00",
               o_count, o_empty, o_full, o_tx_start, o_tx_data);
    end
    exp_q.delete();
    busy = 1'b0;
    last_data = 8'h00;
    step(); step();
    i_reset = 1'b1;
    l0 = launches;
    pulse_done();
    repeat (5) step();
    tests++;
    if (launches !== l0 || s_empty !== 1'b1) begin
      fails++;
      $display("FAIL late_done_ignored: launches=%0d empty=%b, expected %0d 1", launches, s_empty, l0);
    end
    write_byte(8'h5A);
    drain(50);
  endtask

  task automatic test_stray_wrap();
    int l0 = launches;
    int written = 0;
    int n = 0;
    pulse_done();
    repeat (4) step();
    tests++;
    if (launches !== l0 || s_count !== 5'd0) begin
      fails++;
      $display("FAIL stray_done: launches=%0d count=%0d, expected %0d 0", launches, s_count, l0);
    end
    auto_done = 1'b1;
    while ((written < 20 || exp_q.size() != 0 || busy) && n < 2000) begin
      if (written < 20 && exp_q.size() < 14 && $urandom_range(0, 2) == 0) begin
        i_wr = 1'b1; i_wr_data = 8'($urandom);
        written++;
      end
      step();
      i_wr = 1'b0;
      n++;
    end
    auto_done = 1'b0;
    step();
    tests++;
    if (n >= 2000 || launches - l0 !== 20) begin
      fails++;
      $display("FAIL wrap_stream: %0d launches in %0d cycles, expected 20", launches - l0, n);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst_overflow();
    test_simultaneous();
    test_reset_mid();
    test_stray_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
